// File: rtl/uart_pkg.sv
// Shared UART types and baud-increment helper used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [1:0] {TxIdle, TxStartBit, TxData, TxStopBit} TxState;

    typedef enum logic [2:0] {RxIdle, RxStartBit, RxData, RxStopBit, RxDone, RxBreak} RxState;

    // Rounded phase increment so that the accumulator carry rate is baud*oversample.
    function automatic int unsigned baud_inc(input longint unsigned src_freq,
                                             input longint unsigned baud,
                                             input int unsigned     acc_width,
                                             input int unsigned     oversample);
        longint unsigned num;
        num = ((baud * oversample) << (acc_width - 4)) + (src_freq >> 5);
        return 32'(num / (src_freq >> 4));
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Phase-accumulator tick generator: tick_o is the carry bit, one cycle wide, no backpressure.
// clr_i zeroes the accumulator synchronously so the next tick is a full period away.
module uart_baud_gen #(
    parameter int unsigned W   = 16,
    parameter int unsigned INC = 4832
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [W:0] INC_W = (W+1)'(INC);

    logic [W:0] acc_q, acc_d;

    always_comb begin
        acc_d = {1'b0, acc_q[W-1:0]} + INC_W;
        if (clr_i) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign tick_o = acc_q[W];

endmodule

// File: rtl/uart_rx.sv
// 8N1/8N2 UART receiver with 16x mid-bit sampling; strobe lands ~9.5 bit periods after the start edge.
// No backpressure: rx_byte/rx_frame_err are simply overwritten by the next completed frame.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned SOURCE_FREQ       = 25_000_000,
    parameter int unsigned BAUD              = 115200,
    parameter int unsigned ACCUMULATOR_WIDTH = 16,
    parameter int unsigned OVERSAMPLE        = 16,
    parameter int unsigned STOP_BITS         = 1
) (
    input  logic       sourceClk,
    input  logic       reset,
    input  logic       rx_en,
    input  logic       rx_in,
    output logic [7:0] rx_byte,
    output logic       rx_complete,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int unsigned INC = baud_inc(SOURCE_FREQ, BAUD, ACCUMULATOR_WIDTH, OVERSAMPLE);

    RxState     state_q, state_d;
    logic [1:0] sync_q;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [1:0] stop_cnt_q, stop_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       err_q, err_d;
    logic [7:0] byte_q, byte_d;
    logic       cmp_q, cmp_d;
    logic       ferr_q, ferr_d;
    logic       busy_q, busy_d;
    logic       baud_clr;
    logic       tick;
    logic       rxs;

    assign rxs = sync_q[1];

    uart_baud_gen #(
        .W   (ACCUMULATOR_WIDTH),
        .INC (INC)
    ) u_baud (
        .clk_i  (sourceClk),
        .rst_ni (reset),
        .clr_i  (baud_clr),
        .tick_o (tick)
    );

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        err_d      = err_q;
        byte_d     = byte_q;
        cmp_d      = 1'b0;
        ferr_d     = ferr_q;
        busy_d     = busy_q;
        baud_clr   = 1'b0;
        unique case (state_q)
            RxIdle: begin
                busy_d = 1'b0;
                if (!rx_en && !rxs) begin
                    baud_clr   = 1'b1;
                    tick_cnt_d = '0;
                    err_d      = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = RxStartBit;
                end
            end
            RxStartBit: if (tick) begin
                tick_cnt_d = tick_cnt_q + 4'd1;
                // Mid-start-bit check rejects glitches shorter than half a bit.
                if (tick_cnt_q == 4'd7) begin
                    tick_cnt_d = '0;
                    if (!rxs) begin
                        bit_cnt_d = '0;
                        state_d   = RxData;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = RxIdle;
                    end
                end
            end
            RxData: if (tick) begin
                tick_cnt_d = tick_cnt_q + 4'd1;
                if (tick_cnt_q == 4'd15) begin
                    shift_d   = {rxs, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        stop_cnt_d = 2'(STOP_BITS);
                        state_d    = RxStopBit;
                    end
                end
            end
            RxStopBit: if (tick) begin
                tick_cnt_d = tick_cnt_q + 4'd1;
                if (tick_cnt_q == 4'd15) begin
                    err_d      = err_q | ~rxs;
                    stop_cnt_d = stop_cnt_q - 2'd1;
                    if (stop_cnt_q == 2'd1) begin
                        state_d = RxDone;
                    end
                end
            end
            RxDone: begin
                byte_d     = shift_q;
                ferr_d     = err_q;
                cmp_d      = 1'b1;
                tick_cnt_d = '0;
                if (err_q) begin
                    state_d = RxBreak;
                end else begin
                    busy_d  = 1'b0;
                    state_d = RxIdle;
                end
            end
            RxBreak: if (rxs) begin
                // Held-low line must return high before a new start is accepted.
                busy_d  = 1'b0;
                state_d = RxIdle;
            end
            default: state_d = RxIdle;
        endcase
    end

    always_ff @(posedge sourceClk or negedge reset) begin
        if (!reset) begin
            state_q    <= RxIdle;
            sync_q     <= 2'b11;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            shift_q    <= '0;
            err_q      <= 1'b0;
            byte_q     <= '0;
            cmp_q      <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= {sync_q[0], rx_in};
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            err_q      <= err_d;
            byte_q     <= byte_d;
            cmp_q      <= cmp_d;
            ferr_q     <= ferr_d;
            busy_q     <= busy_d;
        end
    end

    assign rx_byte      = byte_q;
    assign rx_complete  = cmp_q;
    assign rx_frame_err = ferr_q;
    assign rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames plus hand-written glitch/reset/enable sequences.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BIT = 217;

    logic       sourceClk = 1'b0;
    logic       reset     = 1'b0;
    logic       rx_en     = 1'b0;
    logic       rx_in     = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_complete;
    logic       rx_frame_err;
    logic       rx_busy;

    uart_rx dut (
        .sourceClk    (sourceClk),
        .reset        (reset),
        .rx_en        (rx_en),
        .rx_in        (rx_in),
        .rx_byte      (rx_byte),
        .rx_complete  (rx_complete),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    always #5 sourceClk = ~sourceClk;

    typedef struct {
        logic [7:0] dat;
        logic       err;
    } exp_t;

    typedef struct {
        logic [7:0] dat;
        int         per;
        int         stop_low;
        int         gap;
        logic       err;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[8];
    int   tests = 0;
    int   fails = 0;
    int   strobes = 0;
    logic busy_seen = 1'b0;
    logic prev_cmp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sourceClk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int per, input int stop_low,
                              input bit expect_it, input logic exp_err);
        exp_t e;
        if (expect_it) begin
            e.dat = d;
            e.err = exp_err;
            exp_q.push_back(e);
        end
        rx_in = 1'b0;
        idle(per);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            idle(per);
        end
        if (stop_low > 0) begin
            rx_in = 1'b0;
            idle(per * stop_low);
        end else begin
            rx_in = 1'b1;
            idle(per);
        end
    endtask

    // Scoreboard: every strobe must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge sourceClk);
            if (rx_busy === 1'b1) busy_seen = 1'b1;
            if (rx_complete === 1'b1) begin
                strobes++;
                check("strobe_width", prev_cmp, 0);
                check("strobe_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("rx_byte", rx_byte, e.dat);
                    check("rx_frame_err", rx_frame_err, e.err);
                end
            end
            prev_cmp = rx_complete;
        end
    end

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [7:0] d;

        tbl[0] = '{8'h55, 217, 0, 300, 1'b0};
        tbl[1] = '{8'hA3, 217, 0, 0,   1'b0};
        tbl[2] = '{8'h00, 217, 0, 0,   1'b0};
        tbl[3] = '{8'hFF, 217, 0, 300, 1'b0};
        tbl[4] = '{8'h3C, 217, 3, 434, 1'b1};
        tbl[5] = '{8'h81, 217, 0, 300, 1'b0};
        tbl[6] = '{8'hC7, 224, 0, 300, 1'b0};
        tbl[7] = '{8'hC7, 210, 0, 300, 1'b0};

        idle(5);
        check("reset_rx_byte", rx_byte, 0);
        check("reset_rx_complete", rx_complete, 0);
        check("reset_rx_frame_err", rx_frame_err, 0);
        check("reset_rx_busy", rx_busy, 0);
        check("reset_state", dut.state_q, RxIdle);
        reset = 1'b1;
        idle(20);

        for (int i = 0; i < 8; i++) begin
            send_frame(tbl[i].dat, tbl[i].per, tbl[i].stop_low, 1'b1, tbl[i].err);
            if (tbl[i].stop_low > 0) begin
                check("break_busy", rx_busy, 1);
                check("break_state", dut.state_q, RxBreak);
            end
            rx_in = 1'b1;
            if (tbl[i].gap > 0) begin
                idle(tbl[i].gap);
                check("idle_busy", rx_busy, 0);
                check("drained", exp_q.size(), 0);
            end
        end
        check("table_strobes", strobes, 8);

        // Short low glitch on an idle line.
        base = strobes;
        busy_seen = 1'b0;
        rx_in = 1'b0;
        idle(60);
        rx_in = 1'b1;
        idle(300);
        check("glitch_busy_pulse", busy_seen, 1);
        check("glitch_busy_clear", rx_busy, 0);
        check("glitch_state", dut.state_q, RxIdle);
        check("glitch_no_strobe", strobes, base);

        // Reset asserted in the middle of data bit 4.
        base = strobes;
        d = 8'hF0;
        rx_in = 1'b0;
        idle(BIT);
        for (int i = 0; i < 4; i++) begin
            rx_in = d[i];
            idle(BIT);
        end
        rx_in = d[4];
        idle(BIT / 2);
        #2 reset = 1'b0;
        #1;
        check("midrst_rx_byte", rx_byte, 0);
        check("midrst_rx_busy", rx_busy, 0);
        check("midrst_rx_complete", rx_complete, 0);
        check("midrst_rx_frame_err", rx_frame_err, 0);
        rx_in = 1'b1;
        idle(20);
        reset = 1'b1;
        idle(BIT * 6);
        check("midrst_no_strobe", strobes, base);
        send_frame(8'h12, BIT, 0, 1'b1, 1'b0);
        idle(300);
        check("after_rst_drained", exp_q.size(), 0);
        check("after_rst_strobe", strobes, base + 1);

        // Receiver disabled: the line is ignored.
        base = strobes;
        rx_en = 1'b1;
        send_frame(8'h99, BIT, 0, 1'b0, 1'b0);
        idle(300);
        check("disabled_no_strobe", strobes, base);
        check("disabled_busy", rx_busy, 0);
        rx_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver for 8N1/8N2 frames; the receive-side counterpart of the team's UART transmitter.
- Shares its baud-generation scheme: a phase accumulator whose carry bit is the tick, run here at 16x the baud rate for mid-bit sampling.
- Delivers each received byte with a one-cycle completion strobe and a framing-error flag.
- Sits between the external RX pin and the multibyte UART controller / core bus interface.

Parameters:
- SOURCE_FREQ, 25_000_000: source clock frequency in Hz.
- BAUD, 115200: line rate in bits/s.
- ACCUMULATOR_WIDTH, 16: phase accumulator width in bits, excluding the carry bit.
- OVERSAMPLE, 16: ticks per bit period. Must be 16.
- STOP_BITS, 1: number of stop bits checked, 1 or 2.

Ports:
- sourceClk  in  1  source clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_en  in  1  receive enable, active low (same polarity as tx_en).
- rx_in  in  1  serial line, asynchronous to sourceClk; idles high.
- rx_byte  out  8  last received byte, held until the next completion.
- rx_complete  out  1  one-cycle strobe: a frame finished and rx_byte/rx_frame_err are updated.
- rx_frame_err  out  1  stop bit sampled low on the last frame; valid with rx_complete, held until the next completion.
- rx_busy  out  1  high from start-edge detect until return to RxIdle.

Behaviour:
- Reset values: rx_byte=0, rx_complete=0, rx_frame_err=0, rx_busy=0, synchronizer flops=1, state=RxIdle, all counters=0. Reset asserted mid-frame aborts it immediately; no rx_complete is produced.
- Synchronizer: rx_in passes through 2 flops; all logic uses only the synchronized value rxs.
- Accumulator: width ACCUMULATOR_WIDTH+1. Increment INC = ((BAUD*OVERSAMPLE << (W-4)) + (SOURCE_FREQ>>5)) / (SOURCE_FREQ>>4), i.e. rounded. With defaults INC=4832. tick = carry bit. Carry is cleared on every tick, and the accumulator and tick count are zeroed on start detect.
- RxIdle:
  - rx_busy=0.
  - If rx_en==0 and rxs==0, zero the accumulator and tick count, set rx_busy=1, go to RxStartBit.
  - If rx_en==1, the line is ignored.
- RxStartBit (mid-bit validation):
  - On the 8th tick, if rxs==0, clear bitCnt and the tick count and go to RxData.
  - Otherwise treat it as a glitch and return to RxIdle; no strobe is produced.
- RxData:
  - Sample rxs on every 16th tick and shift it in at the MSB of the shift register (LSB-first on the wire).
  - bitCnt counts 0..7; after the sample with bitCnt==7, go to RxStopBit with stopCnt=STOP_BITS.
- RxStopBit:
  - Sample on every 16th tick; any low sample sets an error latch.
  - When stopCnt reaches 0, go to RxDone.
- RxDone (one cycle):
  - rx_byte <= shift register, rx_frame_err <= error latch, rx_complete=1.
  - If the error latch is clear, go to RxIdle.
  - If set, go to RxBreak.
- RxBreak: wait until rxs==1, then go to RxIdle. This prevents a held-low line from retriggering.
- rx_complete is high for exactly one cycle per accepted frame, registered.
- Timing: the strobe occurs 2 sync cycles + (8 + 16*(8+STOP_BITS)) ticks + 1 cycle after the falling edge. That is about 9.5 bit periods for STOP_BITS=1.
- rx_en deasserted (high) mid-frame: the current frame completes normally; the next start is not accepted.
- A falling edge arriving in the same cycle as RxDone is picked up on the following cycle from RxIdle. Back-to-back frames with no idle gap must all be received.

Decomposition:
- Shared package uart_pkg holds:
  - typedef enum RxState {RxIdle, RxStartBit, RxData, RxStopBit, RxDone, RxBreak}, next to the existing TxState;
  - a function computing the rounded accumulator increment from SOURCE_FREQ, BAUD, W and OVERSAMPLE, shared with the transmitter.
- One sub-module, uart_baud_gen: accumulator with sync clear, tick output and parameterised increment. It is reusable by the transmitter.

Test Plan:
- Defaults. Drive 0x55 with 1 stop bit at an exact 217-cycle bit period -> one rx_complete; rx_byte=0x55, rx_frame_err=0, rx_busy low afterwards.
- Three back-to-back frames 0xA3, 0x00, 0xFF with no idle gap -> three strobes; rx_byte sequence A3, 00, FF; no errors.
- 60-cycle low glitch on an idle line -> no rx_complete, state returns to RxIdle, rx_busy pulses then clears.
- Frame 0x3C with the stop bit held low for 3 bit periods -> rx_complete with rx_byte=0x3C and rx_frame_err=1. No second strobe until the line goes high and a new frame 0x81 arrives, then rx_byte=0x81 and rx_frame_err=0.
- Transmitter bit period skewed by +3% and then -3% while sending 0xC7 -> both frames received as 0xC7 without error.
- Assert reset during data bit 4 of a frame -> all outputs return to 0 immediately and no strobe occurs; after release, frame 0x12 is received correctly. Also hold rx_en=1 and send 0x99 -> no strobe.
